// File: rtl/fpu_sw_map_pkg.sv
// Software register map of the FPU/SIMD accelerator, shared by the
// write-side dispatcher and the read-data mux.
//   - Register address constants
//   - Command and status register bit positions
//   - Dispatcher state encoding
package fpu_sw_map_pkg;

    localparam logic [31:0] FPU_COMMAND_REGISTER  = 32'h0000_0000;
    localparam logic [31:0] FPU_STATUS_REGISTER_0 = 32'h0000_0110;
    localparam logic [31:0] INPUT_0               = 32'h0000_0120;
    localparam logic [31:0] INPUT_1               = 32'h0000_0124;
    localparam logic [31:0] OUTPUT_0              = 32'h0000_0130;

    // Command register: [OPCODE_W-1:0] opcode, [4] engine select, [31] start
    localparam int CMD_SIMD_BIT  = 4;
    localparam int CMD_START_BIT = 31;

    // Status register: [0] busy, [1] done, [2] err_busy, [3] err_timeout
    localparam int STS_BUSY_BIT        = 0;
    localparam int STS_DONE_BIT        = 1;
    localparam int STS_ERR_BUSY_BIT    = 2;
    localparam int STS_ERR_TIMEOUT_BIT = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } disp_state_e;

endpackage

// File: rtl/sw_datain_dispatcher_if.sv
// Software write bus into the accelerator register map.
//   sw_write_en : write strobe, one write per cycle
//   sw_address  : write address
//   sw_datain   : write data
// master drives the bus, slave (the dispatcher) receives it.
interface sw_datain_dispatcher_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              sw_write_en;
    logic [ADDR_W-1:0] sw_address;
    logic [DATA_W-1:0] sw_datain;

    modport master (output sw_write_en, output sw_address, output sw_datain);
    modport slave  (input  sw_write_en, input  sw_address, input  sw_datain);
endinterface

// File: rtl/sw_timeout_counter.sv
// Abort timer for an in-flight engine operation.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart counting from 0 (operation launch)
//   enable     : count this cycle (operation in flight)
//   expired    : counting and the budget of TIMEOUT_CYCLES cycles is used up
module sw_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The first in-flight cycle sees count 0, so the last allowed one sees
    // TIMEOUT_CYCLES-1.
    assign expired = enable && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/sw_datain_dispatcher.sv
// Software write path into the FPU/SIMD accelerator. Decodes bus writes into
// operand, command and status registers, launches the selected engine with a
// start/ready handshake and tracks completion with an abort timer.
//   clk, rst_n              : clock, asynchronous active-low reset
//   bus (slave)             : sw_write_en / sw_address / sw_datain
//   operand_a, operand_b    : operands from INPUT_0 / INPUT_1
//   op_code, fpu_simd       : opcode and engine select latched at launch
//   fpu_start/ready/done    : FPU request handshake and completion pulse
//   simd_start/ready/done   : SIMD request handshake and completion pulse
//   command_reg, status_reg : readback values for the read-data mux
module sw_datain_dispatcher
    import fpu_sw_map_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int OPCODE_W       = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sw_datain_dispatcher_if.slave bus,
    output logic [DATA_W-1:0]     operand_a,
    output logic [DATA_W-1:0]     operand_b,
    output logic [OPCODE_W-1:0]   op_code,
    output logic                  fpu_simd,
    output logic                  fpu_start,
    input  logic                  fpu_ready,
    input  logic                  fpu_done,
    output logic                  simd_start,
    input  logic                  simd_ready,
    input  logic                  simd_done,
    output logic [DATA_W-1:0]     command_reg,
    output logic [DATA_W-1:0]     status_reg
);
    disp_state_e         state_q, state_d;
    logic [DATA_W-1:0]   operand_a_q, operand_a_d;
    logic [DATA_W-1:0]   operand_b_q, operand_b_d;
    logic [DATA_W-1:0]   command_q, command_d;
    logic [OPCODE_W-1:0] op_code_q, op_code_d;
    logic                fpu_simd_q, fpu_simd_d;
    logic                start_q, start_d;
    logic                done_q, done_d;
    logic                err_busy_q, err_busy_d;
    logic                err_timeout_q, err_timeout_d;

    logic              wr_cmd, wr_sts, wr_in0, wr_in1;
    logic              busy, launch, expired;
    logic              sel_ready, sel_done;
    logic              set_done, set_err_busy, set_err_timeout;
    logic [DATA_W-1:0] w1c;
    logic [3:0]        sts;

    assign wr_cmd = bus.sw_write_en && (bus.sw_address == ADDR_W'(FPU_COMMAND_REGISTER));
    assign wr_sts = bus.sw_write_en && (bus.sw_address == ADDR_W'(FPU_STATUS_REGISTER_0));
    assign wr_in0 = bus.sw_write_en && (bus.sw_address == ADDR_W'(INPUT_0));
    assign wr_in1 = bus.sw_write_en && (bus.sw_address == ADDR_W'(INPUT_1));

    assign busy      = (state_q != IDLE);
    assign sel_ready = fpu_simd_q ? simd_ready : fpu_ready;
    assign sel_done  = fpu_simd_q ? simd_done  : fpu_done;
    assign w1c       = wr_sts ? bus.sw_datain : '0;

    always_comb begin
        state_d         = state_q;
        operand_a_d     = operand_a_q;
        operand_b_d     = operand_b_q;
        command_d       = command_q;
        op_code_d       = op_code_q;
        fpu_simd_d      = fpu_simd_q;
        start_d         = start_q;
        launch          = 1'b0;
        set_done        = 1'b0;
        set_err_timeout = 1'b0;
        set_err_busy    = busy && (wr_cmd || wr_in0 || wr_in1);

        case (state_q)
            IDLE: begin
                if (wr_in0) operand_a_d = bus.sw_datain;
                if (wr_in1) operand_b_d = bus.sw_datain;
                if (wr_cmd) begin
                    command_d                = bus.sw_datain;
                    command_d[CMD_START_BIT] = 1'b0;
                    if (bus.sw_datain[CMD_START_BIT]) begin
                        launch     = 1'b1;
                        op_code_d  = bus.sw_datain[OPCODE_W-1:0];
                        fpu_simd_d = bus.sw_datain[CMD_SIMD_BIT];
                        start_d    = 1'b1;
                        state_d    = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // Completion pulses are not meaningful before the request is accepted.
                if (expired) begin
                    start_d         = 1'b0;
                    set_err_timeout = 1'b1;
                    state_d         = IDLE;
                end else if (sel_ready) begin
                    start_d = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A completion in the expiry cycle still counts as success.
                if (sel_done) begin
                    set_done = 1'b1;
                    state_d  = IDLE;
                end else if (expired) begin
                    set_err_timeout = 1'b1;
                    state_d         = IDLE;
                end
            end
            default: begin
                start_d = 1'b0;
                state_d = IDLE;
            end
        endcase

        // Sticky status: a hardware set beats a same-cycle write-1-to-clear.
        done_d        = ((done_q & ~w1c[STS_DONE_BIT]) | set_done) & ~launch;
        err_busy_d    = (err_busy_q & ~w1c[STS_ERR_BUSY_BIT]) | set_err_busy;
        err_timeout_d = (err_timeout_q & ~w1c[STS_ERR_TIMEOUT_BIT]) | set_err_timeout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            operand_a_q   <= '0;
            operand_b_q   <= '0;
            command_q     <= '0;
            op_code_q     <= '0;
            fpu_simd_q    <= 1'b0;
            start_q       <= 1'b0;
            done_q        <= 1'b0;
            err_busy_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            operand_a_q   <= operand_a_d;
            operand_b_q   <= operand_b_d;
            command_q     <= command_d;
            op_code_q     <= op_code_d;
            fpu_simd_q    <= fpu_simd_d;
            start_q       <= start_d;
            done_q        <= done_d;
            err_busy_q    <= err_busy_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    sw_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (launch),
        .enable  (busy),
        .expired (expired)
    );

    always_comb begin
        sts                      = '0;
        sts[STS_BUSY_BIT]        = busy;
        sts[STS_DONE_BIT]        = done_q;
        sts[STS_ERR_BUSY_BIT]    = err_busy_q;
        sts[STS_ERR_TIMEOUT_BIT] = err_timeout_q;
    end

    assign operand_a   = operand_a_q;
    assign operand_b   = operand_b_q;
    assign op_code     = op_code_q;
    assign fpu_simd    = fpu_simd_q;
    assign fpu_start   = start_q & ~fpu_simd_q;
    assign simd_start  = start_q &  fpu_simd_q;
    assign command_reg = command_q;
    assign status_reg  = DATA_W'(sts);
endmodule
